// File: rtl/bus_memory_pkg.sv
// Shared types and constants for the bus_memory RAM and its host byte loader.
package bus_memory_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_LO = 2'd1,
    LOAD_HI = 2'd2,
    FINISH  = 2'd3
  } load_state_t;

  typedef logic [15:0] word_t;

  localparam word_t CONSOLE_ADDR = 16'hFFFE;

endpackage

// File: rtl/bus_memory_loader.sv
// Host-side byte loader: assembles little-endian words, drives the array write
// port, tracks the word count and holds the CPU in reset while loading.
module bus_memory_loader
  import bus_memory_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   load_words,
  output logic              overflow,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_index,
  output word_t             mem_data
);

  load_state_t     state, state_nxt;
  logic [ADDR_W:0] ptr, ptr_nxt;
  logic [ADDR_W:0] words, words_nxt;
  logic [7:0]      lo, lo_nxt;
  logic            hold_nxt;
  logic            accept;
  logic            full;
  logic            we;
  logic            ovf;

  assign load_ready = (state == LOAD_LO) || (state == LOAD_HI);
  assign accept     = load_valid && load_ready;
  // ptr never passes 2^ADDR_W, so its top bit alone marks a full array
  assign full       = ptr[ADDR_W];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    words_nxt = words;
    lo_nxt    = lo;
    hold_nxt  = cpu_hold;
    we        = 1'b0;
    ovf       = 1'b0;
    mem_data  = {load_byte, lo};
    if (load_start) begin
      state_nxt = LOAD_LO;
      ptr_nxt   = '0;
      words_nxt = '0;
      hold_nxt  = 1'b1;
    end else begin
      case (state)
        LOAD_LO: begin
          if (accept) begin
            lo_nxt = load_byte;
            ovf    = full;
            if (load_last) begin
              if (!full) begin
                we        = 1'b1;
                mem_data  = {8'h00, load_byte};
                ptr_nxt   = ptr + 1'b1;
                words_nxt = words + 1'b1;
              end
              state_nxt = FINISH;
            end else begin
              state_nxt = LOAD_HI;
            end
          end
        end
        LOAD_HI: begin
          if (accept) begin
            ovf = full;
            if (!full) begin
              we        = 1'b1;
              ptr_nxt   = ptr + 1'b1;
              words_nxt = words + 1'b1;
            end
            state_nxt = load_last ? FINISH : LOAD_LO;
          end
        end
        FINISH: begin
          hold_nxt  = 1'b0;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      words    <= '0;
      cpu_hold <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      words    <= words_nxt;
      cpu_hold <= hold_nxt;
    end
  end

  always_ff @(posedge clock) begin
    lo <= lo_nxt;
  end

  assign load_words = words;
  assign mem_index  = ptr[ADDR_W-1:0];
  assign mem_we     = we && !reset;
  assign overflow   = ovf && !reset;

endmodule

// File: rtl/bus_memory.sv
// Word-organised CPU RAM with host byte loader. Optional console port at
// CONSOLE_ADDR when BUS_MEMORY_CONSOLE_EN is defined.
module bus_memory
  import bus_memory_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [15:0]     addr,
  input  logic [15:0]     wdata,
  input  logic            write_enable,
  output logic [15:0]     rdata,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic [7:0]      load_byte,
  input  logic            load_last,
  output logic            load_ready,
  output logic            cpu_hold,
  output logic [ADDR_W:0] load_words,
  output logic            bus_err
`ifdef BUS_MEMORY_CONSOLE_EN
  ,
  output logic            console_valid,
  output logic [7:0]      console_data,
  input  logic            console_ready
`endif
);

  word_t             mem [2**ADDR_W];
  logic [ADDR_W-1:0] index;
  logic              in_range;
  logic              cpu_we;
  logic              cpu_fault;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_index;
  word_t             ld_data;
  logic              ld_overflow;
  logic              addr_unused;

  assign index       = addr[ADDR_W:1];
  assign addr_unused = addr[0];
  assign in_range    = (addr[15:ADDR_W+1] == '0);
  assign cpu_we      = write_enable && in_range && !cpu_hold;
  assign rdata       = (in_range && !cpu_hold) ? mem[index] : 16'h0000;

  bus_memory_loader #(.ADDR_W(ADDR_W)) u_loader (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_last  (load_last),
    .load_ready (load_ready),
    .cpu_hold   (cpu_hold),
    .load_words (load_words),
    .overflow   (ld_overflow),
    .mem_we     (ld_we),
    .mem_index  (ld_index),
    .mem_data   (ld_data)
  );

  // Loader only writes while cpu_hold is high, so the two ports never collide
  always_ff @(posedge clock) begin
    if (ld_we)
      mem[ld_index] <= ld_data;
    else if (cpu_we)
      mem[index] <= wdata;
  end

`ifdef BUS_MEMORY_CONSOLE_EN
  logic console_hit;
  logic console_store;

  assign console_hit   = (addr == CONSOLE_ADDR) && !cpu_hold;
  assign console_store = console_hit && write_enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      console_valid <= 1'b0;
      console_data  <= 8'h00;
    end else if (console_store && !console_valid) begin
      console_valid <= 1'b1;
      console_data  <= wdata[7:0];
    end else if (console_valid && console_ready) begin
      console_valid <= 1'b0;
    end
  end

  always_comb begin
    cpu_fault = !cpu_hold && !in_range;
    if (console_hit)
      cpu_fault = console_store && console_valid;
  end
`else
  always_comb begin
    cpu_fault = !cpu_hold && !in_range;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset)
      bus_err <= 1'b0;
    else if (cpu_fault || ld_overflow)
      bus_err <= 1'b1;
  end

endmodule
